// File: rtl/bus_cap_pkg.sv
// Shared definitions for the 386SX write-capture block: entry layout and FSM states.
// Entry is {io, bhe, ble, A[21:1], D[15:0]}, 40 bits.
package bus_cap_pkg;

    localparam int ENTRY_W   = 40;
    localparam int ENT_IO    = 39;
    localparam int ENT_BHE   = 38;
    localparam int ENT_BLE   = 37;
    localparam int ENT_A_MSB = 36;
    localparam int ENT_A_LSB = 16;
    localparam int ENT_D_MSB = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_T2   = 1'b1
    } state_t;

    typedef logic [ENTRY_W-1:0] entry_t;

endpackage

// File: rtl/bus_write_capture.sv
// Snoops the non-pipelined 386SX bus and pushes each qualified write as a 40-bit entry.
// Push lands 1 cycle after READY#; one entry is held while the FIFO is full, further ones are counted as lost.
module bus_write_capture
    import bus_cap_pkg::*;
#(
    parameter logic [1:0] ADDR_HI = 2'b00,
    parameter bit         CAP_IO  = 1'b1,
    parameter int         OVF_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               ads_n,
    input  logic               ready_n,
    input  logic               w_r_n,
    input  logic               m_io_n,
    input  logic               d_c_n,
    input  logic               bhe_n,
    input  logic               ble_n,
    input  logic [22:0]        addr,
    input  logic [15:0]        data,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [ENTRY_W-1:0] fifo_wr_data,
    output logic               pending,
    output logic [OVF_W-1:0]   ovf_count,
    output logic               busy
);

    state_t state, state_nxt;
    logic   latch, done;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // A fresh ADS# in T2 is a protocol error: drop the old cycle and track the new one.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ads_n) begin
                    state_nxt = ST_T2;
                    latch     = 1'b1;
                end
            end
            ST_T2: begin
                if (!ads_n) begin
                    latch = 1'b1;
                end else if (!ready_n) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_T2);

    logic [22:0] addr_q;
    logic        bhe_q, ble_q, wr_q, mio_q, dc_q, en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            bhe_q  <= 1'b0;
            ble_q  <= 1'b0;
            wr_q   <= 1'b0;
            mio_q  <= 1'b0;
            dc_q   <= 1'b0;
            en_q   <= 1'b0;
        end else if (latch) begin
            addr_q <= addr;
            bhe_q  <= ~bhe_n;
            ble_q  <= ~ble_n;
            wr_q   <= w_r_n;
            mio_q  <= m_io_n;
            dc_q   <= d_c_n;
            en_q   <= enable;
        end
    end

    logic   in_window, qual;
    entry_t entry;

    assign in_window = mio_q ? (addr_q[22:21] == ADDR_HI) : CAP_IO;
    assign qual      = done & en_q & wr_q & dc_q & in_window;

    always_comb begin
        entry                       = '0;
        entry[ENT_IO]               = ~mio_q;
        entry[ENT_BHE]              = bhe_q;
        entry[ENT_BLE]              = ble_q;
        entry[ENT_A_MSB:ENT_A_LSB]  = addr_q[20:0];
        entry[ENT_D_MSB:0]          = data;
    end

    entry_t hold_q;

    // Draining the hold register frees it for a completion arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wr      <= 1'b0;
            fifo_wr_data <= '0;
            pending      <= 1'b0;
            hold_q       <= '0;
            ovf_count    <= '0;
        end else begin
            fifo_wr <= 1'b0;
            if (pending && !fifo_full) begin
                fifo_wr      <= 1'b1;
                fifo_wr_data <= hold_q;
                pending      <= qual;
                if (qual) hold_q <= entry;
            end else if (qual) begin
                if (!pending && !fifo_full) begin
                    fifo_wr      <= 1'b1;
                    fifo_wr_data <= entry;
                end else if (!pending) begin
                    hold_q  <= entry;
                    pending <= 1'b1;
                end else if (ovf_count != '1) begin
                    ovf_count <= ovf_count + OVF_W'(1);
                end
            end
        end
    end

endmodule
